// File: rtl/sitcp_tx_mux.sv
// sitcp_tx_mux: multi-channel transmit concentrator for the SiTCP TCP transmit port.
//
// Each of NCH channels pushes DW-bit words over ready/valid into its own DEPTH-word FIFO. A
// round-robin arbiter grants bursts of up to BURST words and serialises them MSB-first as bytes
// on TCP_TX_WR/TCP_TX_DATA, honouring TCP_TX_FULL.
//
// Optional feature macro: SITCP_TX_HDR_EN. When defined, each burst is framed by two header
// bytes (0xA0|channel, word count - 1). When undefined, raw words are emitted in grant order.
//
// Ports:
//   CLK           system clock, rising edge
//   SYS_RSTn      synchronous active-low reset
//   TCP_OPEN_ACK  connection open; low flushes all FIFOs and holds the block idle
//   IN_VALID      per-channel word valid
//   IN_DATA       channel c in bits [c*DW +: DW]
//   IN_READY      per-channel FIFO can accept
//   TCP_TX_FULL   SiTCP almost-full back-pressure
//   TCP_TX_WR     registered byte write strobe
//   TCP_TX_DATA   registered byte
//   BUSY          state machine not idle
module sitcp_tx_mux #(
   parameter int unsigned NCH   = 4,
   parameter int unsigned DW    = 16,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned BURST = 4
) (
   input  logic              CLK,
   input  logic              SYS_RSTn,
   input  logic              TCP_OPEN_ACK,
   input  logic [NCH-1:0]    IN_VALID,
   input  logic [NCH*DW-1:0] IN_DATA,
   output logic [NCH-1:0]    IN_READY,
   input  logic              TCP_TX_FULL,
   output logic              TCP_TX_WR,
   output logic [7:0]        TCP_TX_DATA,
   output logic              BUSY
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned CW  = AW + 1;
   localparam int unsigned GW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned NW  = $clog2(BURST + 1);
   localparam int unsigned BPW = DW / 8;
   localparam int unsigned BW  = (BPW > 1) ? $clog2(BPW) : 1;

`ifdef SITCP_TX_HDR_EN
   typedef enum logic [1:0] {StIdle, StHdr0, StHdr1, StData} state_e;
`else
   typedef enum logic [1:0] {StIdle, StData} state_e;
`endif

   state_e        state_q;
   logic [GW-1:0] rr_q;
   logic [GW-1:0] g_q;
   logic [NW-1:0] left_q;
   logic [BW-1:0] byte_idx_q;
   logic [DW-1:0] shreg_q;

   // Per-channel FIFO storage and bookkeeping
   logic [DW-1:0] mem    [NCH][DEPTH];
   logic [AW-1:0] wr_ptr [NCH];
   logic [AW-1:0] rd_ptr [NCH];
   logic [CW-1:0] count  [NCH];
   logic [NCH-1:0] push;
   logic [NCH-1:0] pop;
   logic           pop_req;
   logic [DW-1:0]  head_word;

   // A word is popped on the edge that issues its first byte
   assign pop_req   = (state_q == StData) & ~TCP_TX_FULL & (byte_idx_q == '0) & TCP_OPEN_ACK;
   assign head_word = mem[g_q][rd_ptr[g_q]];
   assign BUSY      = (state_q != StIdle);

   always_comb begin
      IN_READY = '0;
      push     = '0;
      pop      = '0;
      for (int c = 0; c < NCH; c++) begin
         IN_READY[c] = TCP_OPEN_ACK & (count[c] != CW'(DEPTH));
         push[c]     = IN_VALID[c] & IN_READY[c];
         pop[c]      = pop_req & (g_q == GW'(c));
      end
   end

   always_ff @(posedge CLK) begin
      if (!SYS_RSTn || !TCP_OPEN_ACK) begin
         for (int c = 0; c < NCH; c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
            count[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
            if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
            case ({push[c], pop[c]})
               2'b10:   count[c] <= count[c] + 1'b1;
               2'b01:   count[c] <= count[c] - 1'b1;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge CLK) begin
      for (int c = 0; c < NCH; c++) begin
         if (push[c]) mem[c][wr_ptr[c]] <= IN_DATA[c*DW +: DW];
      end
   end

   // Round-robin search upward from rr+1; scanning downward lets the nearest hit win
   logic [GW-1:0] arb_g;
   logic          arb_hit;
   logic [NW-1:0] arb_n;
   logic [CW-1:0] cnt_sel;

   always_comb begin
      int unsigned idx;
      idx     = 0;
      arb_g   = '0;
      arb_hit = 1'b0;
      for (int unsigned k = NCH; k >= 1; k--) begin
         idx = (32'(rr_q) + k) % NCH;
         if (count[GW'(idx)] != '0) begin
            arb_g   = GW'(idx);
            arb_hit = 1'b1;
         end
      end
      cnt_sel = count[arb_g];
      if (32'(cnt_sel) > BURST) arb_n = NW'(BURST);
      else                      arb_n = NW'(cnt_sel);
   end

   always_ff @(posedge CLK) begin
      if (!SYS_RSTn) begin
         state_q     <= StIdle;
         rr_q        <= '0;
         g_q         <= '0;
         left_q      <= '0;
         byte_idx_q  <= '0;
         shreg_q     <= '0;
         TCP_TX_WR   <= 1'b0;
         TCP_TX_DATA <= 8'h00;
      end else if (!TCP_OPEN_ACK) begin
         // Abort: drop any partial burst without trailing bytes
         state_q    <= StIdle;
         rr_q       <= '0;
         byte_idx_q <= '0;
         TCP_TX_WR  <= 1'b0;
      end else begin
         TCP_TX_WR <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (arb_hit) begin
                  g_q        <= arb_g;
                  rr_q       <= arb_g;
                  left_q     <= arb_n;
                  byte_idx_q <= '0;
`ifdef SITCP_TX_HDR_EN
                  state_q    <= StHdr0;
`else
                  state_q    <= StData;
`endif
               end
            end
`ifdef SITCP_TX_HDR_EN
            StHdr0: begin
               if (!TCP_TX_FULL) begin
                  TCP_TX_WR   <= 1'b1;
                  TCP_TX_DATA <= {4'hA, 4'(g_q)};
                  state_q     <= StHdr1;
               end
            end
            StHdr1: begin
               if (!TCP_TX_FULL) begin
                  TCP_TX_WR   <= 1'b1;
                  TCP_TX_DATA <= 8'(left_q - 1'b1);
                  state_q     <= StData;
               end
            end
`endif
            StData: begin
               if (!TCP_TX_FULL) begin
                  TCP_TX_WR <= 1'b1;
                  if (byte_idx_q == '0) begin
                     TCP_TX_DATA <= head_word[DW-1 -: 8];
                     shreg_q     <= head_word << 8;
                  end else begin
                     TCP_TX_DATA <= shreg_q[DW-1 -: 8];
                     shreg_q     <= shreg_q << 8;
                  end
                  if (byte_idx_q == BW'(BPW - 1)) begin
                     byte_idx_q <= '0;
                     left_q     <= left_q - 1'b1;
                     if (left_q == NW'(1)) state_q <= StIdle;
                  end else begin
                     byte_idx_q <= byte_idx_q + 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sitcp_tx_mux.sv
// Self-checking bench for sitcp_tx_mux: directed scenarios with random payloads, checked against
// a queue-based model of the arbitration and framing rules.
module tb_sitcp_tx_mux;

   localparam int unsigned NCH   = 4;
   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned BURST = 4;
   localparam int unsigned BPW   = DW / 8;
`ifdef SITCP_TX_HDR_EN
   localparam int unsigned HB = 2;
`else
   localparam int unsigned HB = 0;
`endif

   logic              CLK = 1'b0;
   logic              SYS_RSTn = 1'b0;
   logic              TCP_OPEN_ACK = 1'b0;
   logic [NCH-1:0]    IN_VALID = '0;
   logic [NCH*DW-1:0] IN_DATA = '0;
   logic [NCH-1:0]    IN_READY;
   logic              TCP_TX_FULL = 1'b0;
   logic              TCP_TX_WR;
   logic [7:0]        TCP_TX_DATA;
   logic              BUSY;

   sitcp_tx_mux #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .BURST(BURST)) dut (
      .CLK          (CLK),
      .SYS_RSTn     (SYS_RSTn),
      .TCP_OPEN_ACK (TCP_OPEN_ACK),
      .IN_VALID     (IN_VALID),
      .IN_DATA      (IN_DATA),
      .IN_READY     (IN_READY),
      .TCP_TX_FULL  (TCP_TX_FULL),
      .TCP_TX_WR    (TCP_TX_WR),
      .TCP_TX_DATA  (TCP_TX_DATA),
      .BUSY         (BUSY)
   );

   always #5 CLK = ~CLK;

   int unsigned cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // Byte monitor, sampled mid-cycle
   logic [7:0]  rx_q[$];
   int unsigned rx_cyc[$];
   always @(negedge CLK) begin
      if (TCP_TX_WR === 1'b1) begin
         rx_q.push_back(TCP_TX_DATA);
         rx_cyc.push_back(cyc);
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int unsigned checks = 0;
   int unsigned failures = 0;

   // Reference model: per-channel word queues, rr pointer, expected byte stream
   logic [DW-1:0] mq [NCH][$];
   int unsigned   m_rr = 0;
   logic [7:0]    exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One grant: first non-empty channel after rr, up to BURST words, MSB byte first
   task automatic model_burst();
      int unsigned g;
      int unsigned n;
      bit          found;
      logic [DW-1:0] w;
      g = 0;
      found = 1'b0;
      for (int unsigned k = 1; k <= NCH; k++) begin
         int unsigned c;
         c = (m_rr + k) % NCH;
         if (!found && mq[c].size() > 0) begin
            g = c;
            found = 1'b1;
         end
      end
      if (found) begin
         n = (mq[g].size() < BURST) ? mq[g].size() : BURST;
`ifdef SITCP_TX_HDR_EN
         exp_q.push_back(8'hA0 | 8'(g));
         exp_q.push_back(8'(n - 1));
`endif
         for (int unsigned i = 0; i < n; i++) begin
            w = mq[g].pop_front();
            for (int b = BPW - 1; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
         end
         m_rr = g;
      end
   endtask

   task automatic model_drain();
      int unsigned total;
      do begin
         total = 0;
         for (int c = 0; c < NCH; c++) total += mq[c].size();
         if (total > 0) model_burst();
      end while (total > 0);
   endtask

   task automatic push(input int unsigned ch, input logic [DW-1:0] w,
                       output int unsigned acc_cyc);
      int unsigned b;
      b = 0;
      IN_VALID[ch] = 1'b1;
      IN_DATA[ch*DW +: DW] = w;
      while (!IN_READY[ch] && b < 200) begin
         tick();
         b++;
      end
      check("push_ready", 64'(IN_READY[ch]), 64'd1);
      tick();
      IN_VALID[ch] = 1'b0;
      mq[ch].push_back(w);
      acc_cyc = cyc;
   endtask

   task automatic push_pair(input int unsigned ca, input logic [DW-1:0] wa,
                            input int unsigned cb, input logic [DW-1:0] wb);
      IN_VALID[ca] = 1'b1;
      IN_VALID[cb] = 1'b1;
      IN_DATA[ca*DW +: DW] = wa;
      IN_DATA[cb*DW +: DW] = wb;
      check("pair_ready", 64'(IN_READY[ca] & IN_READY[cb]), 64'd1);
      tick();
      IN_VALID = '0;
      mq[ca].push_back(wa);
      mq[cb].push_back(wb);
   endtask

   // Wait for the expected stream, let it settle, then check length and every byte
   task automatic wait_and_compare(input string tag, input bit rand_full);
      int unsigned b;
      int unsigned n;
      b = 0;
      while (rx_q.size() < exp_q.size() && b < 5000) begin
         if (rand_full) TCP_TX_FULL = ($urandom_range(0, 3) == 0);
         tick();
         b++;
      end
      TCP_TX_FULL = 1'b0;
      repeat (8) tick();
      check({tag, "_len"}, 64'(rx_q.size()), 64'(exp_q.size()));
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int unsigned i = 0; i < n; i++) check(tag, 64'(rx_q[i]), 64'(exp_q[i]));
   endtask

   task automatic clear_streams();
      rx_q.delete();
      rx_cyc.delete();
      exp_q.delete();
   endtask

   initial begin
      int unsigned t;
      int unsigned k;
      int unsigned b;
      int unsigned ready_cyc;
      int unsigned n0;
      logic [DW-1:0] w;

      // Reset
      repeat (3) tick();
      check("rst_wr", 64'(TCP_TX_WR), 64'd0);
      check("rst_data", 64'(TCP_TX_DATA), 64'h00);
      check("rst_busy", 64'(BUSY), 64'd0);
      check("rst_ready", 64'(IN_READY), 64'd0);
      SYS_RSTn = 1'b1;
      TCP_OPEN_ACK = 1'b1;
      tick();
      check("open_ready", 64'(IN_READY), 64'hF);

      // Single word on ch2: latency and consecutive bytes
      push(2, 16'hBEEF, t);
      model_burst();
      wait_and_compare("single", 1'b0);
      if (rx_cyc.size() >= HB + 2) begin
         check("first_latency", 64'(rx_cyc[0]), 64'(t + 2));
         for (int unsigned i = 1; i < HB + 2; i++)
            check("consecutive", 64'(rx_cyc[i]), 64'(rx_cyc[0] + i));
      end else begin
         check("single_cnt", 64'(rx_cyc.size()), 64'(HB + 2));
      end
      check("single_busy", 64'(BUSY), 64'd0);
      clear_streams();

      // Round robin: prime ch3, then load ch0 and ch3 with 6 words each while stalled
      TCP_TX_FULL = 1'b1;
      push(3, 16'($urandom), t);
      model_burst();
      for (int i = 0; i < 6; i++) push_pair(0, 16'($urandom), 3, 16'($urandom));
      model_drain();
      TCP_TX_FULL = 1'b0;
      wait_and_compare("rr", 1'b0);
      clear_streams();

      // Back-pressure for 5 cycles mid-DATA
      TCP_TX_FULL = 1'b1;
      push(1, 16'($urandom), t);
      model_burst();
      for (int i = 0; i < 4; i++) push(1, 16'($urandom), t);
      model_drain();
      TCP_TX_FULL = 1'b0;
      k = 0;
      b = 0;
      while (k < 8 && b < 200) begin
         tick();
         if (TCP_TX_WR === 1'b1) k++;
         b++;
      end
      TCP_TX_FULL = 1'b1;
      repeat (5) tick();
      TCP_TX_FULL = 1'b0;
      wait_and_compare("bp", 1'b0);
      if (rx_cyc.size() > 8) begin
         check("bp_gap", 64'(rx_cyc[8] - rx_cyc[7]), 64'd6);
         check("bp_pre", 64'(rx_cyc[7] - rx_cyc[6]), 64'd1);
      end else begin
         check("bp_cnt", 64'(rx_cyc.size()), 64'd9);
      end
      clear_streams();

      // FIFO full on ch1: 16 accepts, 17th waits for the first pop
      TCP_TX_FULL = 1'b1;
      push(1, 16'($urandom), t);
      model_burst();
      for (int i = 0; i < 15; i++) push(1, 16'($urandom), t);
      check("full_ready1", 64'(IN_READY[1]), 64'd0);
      check("full_ready0", 64'(IN_READY[0]), 64'd1);
      w = 16'($urandom);
      IN_VALID[1] = 1'b1;
      IN_DATA[1*DW +: DW] = w;
      tick();
      check("full_hold", 64'(IN_READY[1]), 64'd0);
      TCP_TX_FULL = 1'b0;
      b = 0;
      while (!IN_READY[1] && b < 100) begin
         tick();
         b++;
      end
      ready_cyc = cyc;
      check("full_wait_ready", 64'(IN_READY[1]), 64'd1);
      tick();
      IN_VALID[1] = 1'b0;
      mq[1].push_back(w);
      model_drain();
      wait_and_compare("full", 1'b0);
      if (rx_cyc.size() > HB) check("accept_after_pop", 64'(ready_cyc), 64'(rx_cyc[HB]));
      else check("full_cnt", 64'(rx_cyc.size()), 64'(HB + 1));
      clear_streams();

      // Abort mid-burst
      TCP_TX_FULL = 1'b1;
      push(2, 16'($urandom), t);
      for (int i = 0; i < 4; i++) push(2, 16'($urandom), t);
      TCP_TX_FULL = 1'b0;
      k = 0;
      b = 0;
      while (k < 3 && b < 200) begin
         tick();
         if (TCP_TX_WR === 1'b1) k++;
         b++;
      end
      TCP_OPEN_ACK = 1'b0;
      tick();
      check("abort_wr", 64'(TCP_TX_WR), 64'd0);
      check("abort_ready", 64'(IN_READY), 64'd0);
      check("abort_busy", 64'(BUSY), 64'd0);
      repeat (3) tick();
      for (int c = 0; c < NCH; c++) mq[c].delete();
      m_rr = 0;
      n0 = rx_q.size();
      TCP_OPEN_ACK = 1'b1;
      repeat (20) tick();
      check("no_stale", 64'(rx_q.size()), 64'(n0));
      check("reopen_ready", 64'(IN_READY), 64'hF);
      check("reopen_busy", 64'(BUSY), 64'd0);
      clear_streams();

      // rr restarts at 0 after abort: ch1 is granted before ch0
      push_pair(0, 16'($urandom), 1, 16'($urandom));
      model_drain();
      wait_and_compare("post_abort", 1'b0);
      clear_streams();

      // Random loads with random back-pressure
      for (int it = 0; it < 3; it++) begin
         int unsigned p;
         p = $urandom_range(0, NCH - 1);
         TCP_TX_FULL = 1'b1;
         push(p, 16'($urandom), t);
         model_burst();
         for (int c = 0; c < NCH; c++) begin
            int unsigned cnt;
            cnt = $urandom_range(0, DEPTH - 2);
            for (int unsigned i = 0; i < cnt; i++) push(c, 16'($urandom), t);
         end
         model_drain();
         wait_and_compare("rand", 1'b1);
         clear_streams();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
